// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment codes, frame width and scan FSM state type
package seg7_pkg;

    localparam int FRAME_W = 16;

    // Common-anode, active-low, bit order {dp,g,f,e,d,c,b,a}; dp held off
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD to active-low 7-segment code, non-BCD blanks
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hc595_scan_driver.sv
// rtl/hc595_scan_driver.sv - 4-digit multiplexed display driver over a two-chip 74HC595 chain
// Optional: LEADING_ZERO_BLANK_EN blanks leading zeros of the snapshot (units digit never blanked).
module hc595_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dig_0,
    input  logic [3:0] dig_1,
    input  logic [3:0] dig_2,
    input  logic [3:0] dig_3,
    output logic       dio,
    output logic       sclk,
    output logic       rclk,
    output logic [1:0] scan_idx
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BIT_W  = $clog2(FRAME_W);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W - 1);

    state_t               state_q;
    logic [3:0][3:0]      snap_q;
    logic [FRAME_W-1:0]   shreg_q;
    logic [DIV_W-1:0]     div_q;
    logic [HOLD_W-1:0]    hold_q;
    logic [BIT_W-1:0]     bit_q;
    logic                 phase_q;
    logic                 dio_q;
    logic                 sclk_q;
    logic                 rclk_q;
    logic [1:0]           scan_q;

    logic [3:0][3:0]      live_digits;
    logic [3:0][3:0]      src_digits;
    logic [3:0]           lz_blank;
    logic [7:0]           seg_raw;
    logic [7:0]           seg_sel;
    logic [FRAME_W-1:0]   frame_d;

    assign live_digits = {dig_3, dig_2, dig_1, dig_0};
    // Digit 0's LOAD is also the snapshot capture, so its frame must see the live inputs
    assign src_digits  = (scan_q == 2'd0) ? live_digits : snap_q;

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_blank    = 4'b0000;
        lz_blank[3] = (src_digits[3] == 4'd0);
        lz_blank[2] = lz_blank[3] && (src_digits[2] == 4'd0);
        lz_blank[1] = lz_blank[2] && (src_digits[1] == 4'd0);
    end
`else
    assign lz_blank = 4'b0000;
`endif

    bcd_to_seg7 u_bcd_to_seg7 (
        .bcd_i (src_digits[scan_q]),
        .seg_o (seg_raw)
    );

    assign seg_sel = lz_blank[scan_q] ? SEG_BLANK : seg_raw;
    assign frame_d = {seg_sel, 8'h01 << scan_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            snap_q  <= '0;
            shreg_q <= '0;
            div_q   <= '0;
            hold_q  <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            dio_q   <= 1'b0;
            sclk_q  <= 1'b0;
            rclk_q  <= 1'b0;
            scan_q  <= 2'd0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (scan_q == 2'd0) snap_q <= live_digits;
                    shreg_q <= frame_d;
                    dio_q   <= frame_d[FRAME_W-1];
                    sclk_q  <= 1'b0;
                    rclk_q  <= 1'b0;
                    div_q   <= '0;
                    bit_q   <= '0;
                    phase_q <= 1'b0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (!phase_q) begin
                            phase_q <= 1'b1;
                            sclk_q  <= 1'b1;
                        end else begin
                            // dio only moves on the same edge that drops sclk
                            phase_q <= 1'b0;
                            sclk_q  <= 1'b0;
                            if (bit_q == BIT_LAST) begin
                                rclk_q  <= 1'b1;
                                state_q <= LATCH;
                            end else begin
                                bit_q   <= bit_q + 1'b1;
                                shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
                                dio_q   <= shreg_q[FRAME_W-2];
                            end
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                LATCH: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        rclk_q  <= 1'b0;
                        hold_q  <= '0;
                        state_q <= HOLD;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        scan_q  <= scan_q + 2'd1;
                        state_q <= LOAD;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign dio      = dio_q;
    assign sclk     = sclk_q;
    assign rclk     = rclk_q;
    assign scan_idx = scan_q;

endmodule

// File: tb/tb_hc595_scan_driver.sv
// tb/tb_hc595_scan_driver.sv - scoreboard bench decoding the serial frames of hc595_scan_driver
module tb_hc595_scan_driver;

    localparam int CLK_DIV = 2;
    localparam int HOLD    = 3;
    localparam int PERIOD  = 1 + 33 * CLK_DIV + HOLD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dig_0 = 4'd0, dig_1 = 4'd0, dig_2 = 4'd0, dig_3 = 4'd0;
    logic       dio, sclk, rclk;
    logic [1:0] scan_idx;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [15:0] got_frame[$];
    logic [1:0]  got_idx[$];
    int          got_bits[$];
    logic [15:0] exp_frame[$];
    logic [1:0]  exp_idx[$];

    int rclk_count = 0;
    int rclk_times[$];
    int rclk_w[$];
    int sclk_hi_seen = 0, sclk_hi_bad = 0, dio_viol = 0;

    logic        prev_sclk = 1'b0, prev_rclk = 1'b0, prev_dio = 1'b0;
    logic [15:0] acc = '0;
    int          bit_cnt = 0, sclk_hi = 0, rclk_hi = 0;

    hc595_scan_driver #(.CLK_DIV(CLK_DIV), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst),
        .dig_0(dig_0), .dig_1(dig_1), .dig_2(dig_2), .dig_3(dig_3),
        .dio(dio), .sclk(sclk), .rclk(rclk), .scan_idx(scan_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Plays the part of the 74HC595 pair: shifts on sclk rise, reports a frame on rclk rise
    always @(negedge clk) begin
        if (rst) begin
            bit_cnt = 0; acc = '0; sclk_hi = 0; rclk_hi = 0;
            prev_sclk = 1'b0; prev_rclk = 1'b0; prev_dio = 1'b0;
        end else begin
            if (sclk && !prev_sclk) begin
                acc = {acc[14:0], dio};
                bit_cnt++;
            end
            if (sclk && prev_sclk && (dio !== prev_dio)) dio_viol++;
            if (sclk) sclk_hi++;
            else if (prev_sclk) begin
                sclk_hi_seen++;
                if (sclk_hi != CLK_DIV) sclk_hi_bad++;
                sclk_hi = 0;
            end
            if (rclk && !prev_rclk) begin
                got_frame.push_back(acc);
                got_idx.push_back(scan_idx);
                got_bits.push_back(bit_cnt);
                rclk_times.push_back(cyc);
                rclk_count++;
                bit_cnt = 0;
            end
            if (rclk) rclk_hi++;
            else if (prev_rclk) begin
                rclk_w.push_back(rclk_hi);
                rclk_hi = 0;
            end
            prev_sclk = sclk; prev_rclk = rclk; prev_dio = dio;
        end
    end

    task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
        dig_3 = d3; dig_2 = d2; dig_1 = d1; dig_0 = d0;
    endtask

    task automatic clear_sb();
        got_frame.delete(); got_idx.delete(); got_bits.delete();
        exp_frame.delete(); exp_idx.delete();
        rclk_times.delete(); rclk_w.delete();
        sclk_hi_seen = 0; sclk_hi_bad = 0; dio_viol = 0;
    endtask

    task automatic apply_reset(input logic [3:0] d3, d2, d1, d0);
        @(negedge clk);
        rst = 1'b1;
        set_digits(d3, d2, d1, d0);
        repeat (2) @(negedge clk);
        clear_sb();
        rst = 1'b0;
    endtask

    task automatic expect_frame(input logic [15:0] f, input logic [1:0] idx);
        exp_frame.push_back(f);
        exp_idx.push_back(idx);
    endtask

    task automatic wait_frames(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * PERIOD * (n + 1); i++) begin
            @(negedge clk);
            if (got_frame.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_scan(input logic [1:0] idx, input bit need_sclk, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 * PERIOD; i++) begin
            @(negedge clk);
            if (scan_idx == idx && (!need_sclk || sclk)) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        bit ok;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (dio !== 1'b0) $display("FAIL reset_dio got %b want 0", dio); else n_pass++;
        n_checks++; if (sclk !== 1'b0) $display("FAIL reset_sclk got %b want 0", sclk); else n_pass++;
        n_checks++; if (rclk !== 1'b0) $display("FAIL reset_rclk got %b want 0", rclk); else n_pass++;
        n_checks++; if (scan_idx !== 2'd0) $display("FAIL reset_scan_idx got %0d want 0", scan_idx); else n_pass++;
        clear_sb();
        rst = 1'b0;
    endtask

    task automatic test_basic_frames();
        bit ok;
        expect_frame(16'h9901, 2'd0);
        expect_frame(16'hB002, 2'd1);
        expect_frame(16'hA404, 2'd2);
        expect_frame(16'hF908, 2'd3);
        wait_frames(4, ok);
        n_checks++; if (!ok) $display("FAIL basic_timeout got %0d frames want 4", got_frame.size()); else n_pass++;
        while (exp_frame.size() > 0 && got_frame.size() > 0) begin
            logic [15:0] f, ef; logic [1:0] ix, ei; int b;
            f = got_frame.pop_front(); ix = got_idx.pop_front(); b = got_bits.pop_front();
            ef = exp_frame.pop_front(); ei = exp_idx.pop_front();
            n_checks++; if (f !== ef) $display("FAIL basic_frame got %h want %h", f, ef); else n_pass++;
            n_checks++; if (ix !== ei) $display("FAIL basic_idx got %0d want %0d", ix, ei); else n_pass++;
            n_checks++; if (b != 16) $display("FAIL basic_bits got %0d want 16", b); else n_pass++;
        end
    endtask

    task automatic test_snapshot();
        bit ok;
        got_frame.delete(); got_idx.delete(); got_bits.delete();
        expect_frame(16'h9901, 2'd0);
        wait_scan(2'd1, 1'b0, ok);
        n_checks++; if (!ok) $display("FAIL snap_wait got scan %0d want 1", scan_idx); else n_pass++;
        set_digits(4'd5, 4'd6, 4'd7, 4'd8);
        expect_frame(16'hB002, 2'd1);
        expect_frame(16'hA404, 2'd2);
        expect_frame(16'hF908, 2'd3);
        expect_frame(16'h8001, 2'd0);
        wait_frames(5, ok);
        n_checks++; if (!ok) $display("FAIL snap_timeout got %0d frames want 5", got_frame.size()); else n_pass++;
        while (exp_frame.size() > 0 && got_frame.size() > 0) begin
            logic [15:0] f, ef; logic [1:0] ix, ei; int b;
            f = got_frame.pop_front(); ix = got_idx.pop_front(); b = got_bits.pop_front();
            ef = exp_frame.pop_front(); ei = exp_idx.pop_front();
            n_checks++; if (f !== ef) $display("FAIL snap_frame got %h want %h", f, ef); else n_pass++;
            n_checks++; if (ix !== ei) $display("FAIL snap_idx got %0d want %0d", ix, ei); else n_pass++;
        end
    endtask

    task automatic test_blank_code();
        bit ok;
        apply_reset(4'd1, 4'd2, 4'd3, 4'hA);
        expect_frame(16'hFF01, 2'd0);
        wait_frames(1, ok);
        n_checks++; if (!ok) $display("FAIL blank_timeout got %0d frames want 1", got_frame.size()); else n_pass++;
        while (exp_frame.size() > 0 && got_frame.size() > 0) begin
            logic [15:0] f, ef; logic [1:0] ix, ei;
            f = got_frame.pop_front(); ix = got_idx.pop_front();
            ef = exp_frame.pop_front(); ei = exp_idx.pop_front();
            n_checks++; if (f !== ef) $display("FAIL blank_frame got %h want %h", f, ef); else n_pass++;
            n_checks++; if (ix !== ei) $display("FAIL blank_idx got %0d want %0d", ix, ei); else n_pass++;
        end
    endtask

    task automatic test_timing();
        bit ok;
        apply_reset(4'd1, 4'd2, 4'd3, 4'd4);
        wait_frames(3, ok);
        n_checks++; if (!ok) $display("FAIL timing_timeout got %0d frames want 3", got_frame.size()); else n_pass++;
        if (ok) begin
            n_checks++;
            if (rclk_times[1] - rclk_times[0] != PERIOD)
                $display("FAIL timing_period0 got %0d want %0d", rclk_times[1] - rclk_times[0], PERIOD);
            else n_pass++;
            n_checks++;
            if (rclk_times[2] - rclk_times[1] != PERIOD)
                $display("FAIL timing_period1 got %0d want %0d", rclk_times[2] - rclk_times[1], PERIOD);
            else n_pass++;
            n_checks++;
            if (rclk_w.size() < 2 || rclk_w[0] != CLK_DIV || rclk_w[1] != CLK_DIV)
                $display("FAIL timing_rclk_width got %0d pulses first %0d want %0d", rclk_w.size(),
                         (rclk_w.size() > 0) ? rclk_w[0] : -1, CLK_DIV);
            else n_pass++;
            n_checks++;
            if (sclk_hi_seen != 48 || sclk_hi_bad != 0)
                $display("FAIL timing_sclk_width got %0d pulses %0d bad want 48 pulses 0 bad", sclk_hi_seen, sclk_hi_bad);
            else n_pass++;
            n_checks++;
            if (dio_viol != 0) $display("FAIL timing_dio_stable got %0d changes want 0", dio_viol); else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int cnt_before, cnt_rel;
        apply_reset(4'd1, 4'd2, 4'd3, 4'd4);
        wait_scan(2'd2, 1'b1, ok);
        n_checks++; if (!ok) $display("FAIL midrst_wait got scan %0d want 2 with sclk high", scan_idx); else n_pass++;
        cnt_before = rclk_count;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (dio !== 1'b0) $display("FAIL midrst_dio got %b want 0", dio); else n_pass++;
        n_checks++; if (sclk !== 1'b0) $display("FAIL midrst_sclk got %b want 0", sclk); else n_pass++;
        n_checks++; if (rclk !== 1'b0) $display("FAIL midrst_rclk got %b want 0", rclk); else n_pass++;
        n_checks++; if (scan_idx !== 2'd0) $display("FAIL midrst_scan_idx got %0d want 0", scan_idx); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (rclk_count != cnt_before) $display("FAIL midrst_no_latch got %0d want %0d", rclk_count, cnt_before); else n_pass++;
        clear_sb();
        rst = 1'b0;
        cnt_rel = rclk_count;
        expect_frame(16'h9901, 2'd0);
        wait_frames(1, ok);
        n_checks++; if (!ok) $display("FAIL midrst_timeout got %0d frames want 1", got_frame.size()); else n_pass++;
        n_checks++; if (rclk_count != cnt_rel + 1) $display("FAIL midrst_pulses got %0d want %0d", rclk_count - cnt_rel, 1); else n_pass++;
        while (exp_frame.size() > 0 && got_frame.size() > 0) begin
            logic [15:0] f, ef; logic [1:0] ix, ei; int b;
            f = got_frame.pop_front(); ix = got_idx.pop_front(); b = got_bits.pop_front();
            ef = exp_frame.pop_front(); ei = exp_idx.pop_front();
            n_checks++; if (f !== ef) $display("FAIL midrst_frame got %h want %h", f, ef); else n_pass++;
            n_checks++; if (ix !== ei) $display("FAIL midrst_idx got %0d want %0d", ix, ei); else n_pass++;
            n_checks++; if (b != 16) $display("FAIL midrst_bits got %0d want 16", b); else n_pass++;
        end
    endtask

    task automatic test_leading_zero();
        bit ok;
        apply_reset(4'd0, 4'd0, 4'd0, 4'd7);
        expect_frame(16'hF801, 2'd0);
`ifdef LEADING_ZERO_BLANK_EN
        expect_frame(16'hFF02, 2'd1);
        expect_frame(16'hFF04, 2'd2);
        expect_frame(16'hFF08, 2'd3);
`else
        expect_frame(16'hC002, 2'd1);
        expect_frame(16'hC004, 2'd2);
        expect_frame(16'hC008, 2'd3);
`endif
        wait_frames(4, ok);
        n_checks++; if (!ok) $display("FAIL lz_timeout got %0d frames want 4", got_frame.size()); else n_pass++;
        while (exp_frame.size() > 0 && got_frame.size() > 0) begin
            logic [15:0] f, ef; logic [1:0] ix, ei;
            f = got_frame.pop_front(); ix = got_idx.pop_front();
            ef = exp_frame.pop_front(); ei = exp_idx.pop_front();
            n_checks++; if (f !== ef) $display("FAIL lz_frame got %h want %h", f, ef); else n_pass++;
            n_checks++; if (ix !== ei) $display("FAIL lz_idx got %0d want %0d", ix, ei); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_frames();
        test_snapshot();
        test_blank_code();
        test_timing();
        test_reset_midframe();
        test_leading_zero();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
